// File: rtl/weight_seq_pkg.sv
// Shared encodings for the layer 10-16 weight-mux sequencer: FSM states,
// conv source select codes and the default conv count.
package weight_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] CONV8_SEL  = 3'd0;
  localparam logic [2:0] CONV9_SEL  = 3'd1;
  localparam logic [2:0] CONV10_SEL = 3'd2;
  localparam logic [2:0] CONV11_SEL = 3'd3;
  localparam logic [2:0] CONV12_SEL = 3'd4;

  localparam int N_CONV_L10 = 5;

  typedef logic [2:0] conv_sel_t;

endpackage

// File: rtl/weight_mux_sequencer_l10_chk.sv
// Property checker for the weight-mux sequencer output contract.
module weight_mux_sequencer_l10_chk #(
  parameter int N_CONV = 5
) (
  input logic       clk,
  input logic       rst_n,
  input logic       busy,
  input logic       wt_valid,
  input logic       layer_done,
  input logic [2:0] u
);

  a_u_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    busy |-> (int'(u) < N_CONV));

  a_valid_in_issue: assert property (@(posedge clk) disable iff (!rst_n)
    wt_valid |-> (busy && !layer_done));

  a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
    layer_done |=> !layer_done);

endmodule

// File: rtl/weight_mux_sequencer_l10_wrap_counter.sv
// Modulo (MAX+1) up-counter with synchronous clear; wrap flags the terminal
// count so a parent can chain counters.
module wrap_counter #(
  parameter int W   = 3,
  parameter int MAX = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_r;

  assign count = count_r;
  assign wrap  = (count_r == MAX_V);

  // Count register: clear wins over enable, wraps to zero after MAX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (en) begin
      if (count_r == MAX_V) begin
        count_r <= {W{1'b0}};
      end else begin
        count_r <= count_r + W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/weight_mux_sequencer_l10.sv
// Walks conv8..conv12, issuing TILES_PER_CONV weight tiles per conv over a
// valid/ready handshake, then pulses layer_done once.
module weight_mux_sequencer_l10
  import weight_seq_pkg::*;
#(
  parameter int N_CONV         = N_CONV_L10,
  parameter int TILES_PER_CONV = 8,
  parameter int TILE_W         = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              wt_ready,
  output logic [2:0]        u,
  output logic [TILE_W-1:0] tile_idx,
  output logic              wt_valid,
  output logic              busy,
  output logic              layer_done
);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic       wt_valid_r;
  logic       busy_r;
  logic       layer_done_r;
  logic       hs_s;
  logic       tile_wrap_s;
  logic       conv_wrap_s;
  logic       tile_en_s;
  logic       conv_en_s;
  logic       cnt_clr_s;
  conv_sel_t  conv_sel_s;

  // wt_valid is only ever high in ISSUE, so it qualifies the handshake alone
  assign hs_s      = wt_valid_r & wt_ready;
  assign tile_en_s = hs_s & ~abort;
  assign conv_en_s = tile_en_s & tile_wrap_s;
  assign cnt_clr_s = abort | (state_r != ST_ISSUE);

  wrap_counter #(
    .W   (TILE_W),
    .MAX (TILES_PER_CONV - 1)
  ) u_tile_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_s),
    .en    (tile_en_s),
    .count (tile_idx),
    .wrap  (tile_wrap_s)
  );

  wrap_counter #(
    .W   (3),
    .MAX (N_CONV - 1)
  ) u_conv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_s),
    .en    (conv_en_s),
    .count (conv_sel_s),
    .wrap  (conv_wrap_s)
  );

  // Next-state decode; abort overrides both the final handshake and DONE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (hs_s && tile_wrap_s && conv_wrap_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and status outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      wt_valid_r   <= 1'b0;
      busy_r       <= 1'b0;
      layer_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      wt_valid_r   <= (state_nxt_s == ST_ISSUE);
      busy_r       <= (state_nxt_s != ST_IDLE);
      layer_done_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign u          = conv_sel_s;
  assign wt_valid   = wt_valid_r;
  assign busy       = busy_r;
  assign layer_done = layer_done_r;

endmodule

// File: tb/tb_weight_mux_sequencer_l10.sv
// Randomised and directed bench for weight_mux_sequencer_l10 against a
// flat-tile-index reference model.
module tb_weight_mux_sequencer_l10;

  localparam int NC    = 5;
  localparam int TP    = 8;
  localparam int TW    = 3;
  localparam int TOTAL = NC * TP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          wt_ready = 1'b0;
  logic [2:0]    u;
  logic [TW-1:0] tile_idx;
  logic          wt_valid, busy, layer_done;

  logic          start2 = 1'b0;
  logic          ready2 = 1'b0;
  logic [2:0]    u2;
  logic [0:0]    tile2;
  logic          valid2, busy2, done2;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: running flag, done-pulse flag, flat tile index
  bit m_run  = 1'b0;
  bit m_done = 1'b0;
  int m_idx  = 0;

  int hs_obs, done_obs, cyc, first_valid_cyc, done_cyc;
  int s_u, s_tile;
  bit s_busy;

  weight_mux_sequencer_l10 #(.N_CONV(NC), .TILES_PER_CONV(TP), .TILE_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .wt_ready(wt_ready),
    .u(u), .tile_idx(tile_idx), .wt_valid(wt_valid), .busy(busy), .layer_done(layer_done)
  );

  weight_mux_sequencer_l10 #(.N_CONV(2), .TILES_PER_CONV(1), .TILE_W(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .wt_ready(ready2),
    .u(u2), .tile_idx(tile2), .wt_valid(valid2), .busy(busy2), .layer_done(done2)
  );

  weight_mux_sequencer_l10_chk #(.N_CONV(NC)) chk1 (
    .clk(clk), .rst_n(rst_n), .busy(busy), .wt_valid(wt_valid), .layer_done(layer_done), .u(u)
  );

  weight_mux_sequencer_l10_chk #(.N_CONV(2)) chk2 (
    .clk(clk), .rst_n(rst_n), .busy(busy2), .wt_valid(valid2), .layer_done(done2), .u(u2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_obs();
    hs_obs = 0; done_obs = 0; cyc = 0; first_valid_cyc = -1; done_cyc = -1;
  endtask

  // compare outputs at negedge, advance the model with the current inputs
  task automatic cycle();
    @(negedge clk);
    check_eq("wt_valid", 32'(wt_valid), 32'(m_run));
    check_eq("busy", 32'(busy), 32'(m_run | m_done));
    check_eq("layer_done", 32'(layer_done), 32'(m_done));
    check_eq("u", 32'(u), 32'(m_idx / TP));
    check_eq("tile_idx", 32'(tile_idx), 32'(m_idx % TP));
    cyc++;
    if (wt_valid && wt_ready) hs_obs++;
    if (wt_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (layer_done) begin done_obs++; done_cyc = cyc; end
    s_u = int'(u); s_tile = int'(tile_idx); s_busy = busy;
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_run) begin
      if (abort) begin
        m_run = 1'b0; m_idx = 0;
      end else if (wt_ready) begin
        if (m_idx == TOTAL - 1) begin m_run = 1'b0; m_done = 1'b1; m_idx = 0; end
        else m_idx++;
      end
    end else if (start && !abort) begin
      m_run = 1'b1; m_idx = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_to(input int idx);
    for (int g = 0; g < 200 && !(m_run && m_idx == idx); g++) cycle();
  endtask

  initial begin
    int hs2, done2c, maxu2;
    int hsu[2];

    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_u", 32'(u), 32'd0);
    check_eq("rst_tile", 32'(tile_idx), 32'd0);
    check_eq("rst_valid", 32'(wt_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(layer_done), 32'd0);
    rst_n = 1'b1;

    // async reset in the middle of a sweep
    start = 1'b1; wt_ready = 1'b1; cycle(); start = 1'b0;
    run_to(2 * TP + 5);
    #2;
    check_eq("s1_pre_u", 32'(u), 32'd2);
    check_eq("s1_pre_tile", 32'(tile_idx), 32'd5);
    rst_n = 1'b0;
    #1;
    check_eq("s1_u", 32'(u), 32'd0);
    check_eq("s1_tile", 32'(tile_idx), 32'd0);
    check_eq("s1_valid", 32'(wt_valid), 32'd0);
    check_eq("s1_busy", 32'(busy), 32'd0);
    m_run = 1'b0; m_done = 1'b0; m_idx = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; wt_ready = 1'b0;
    cycle();

    // full sweep with ready held high
    clear_obs();
    start = 1'b1; wt_ready = 1'b1; cycle(); start = 1'b0;
    repeat (TOTAL + 10) cycle();
    check_eq("s2_handshakes", 32'(hs_obs), 32'(TOTAL));
    check_eq("s2_done_count", 32'(done_obs), 32'd1);
    check_eq("s2_done_latency", 32'(done_cyc - first_valid_cyc + 1), 32'(TOTAL + 1));

    // back-pressure at u=1, tile=3
    clear_obs();
    start = 1'b1; cycle(); start = 1'b0;
    run_to(TP + 3);
    wt_ready = 1'b0;
    repeat (3) cycle();
    check_eq("s3_hold_u", 32'(s_u), 32'd1);
    check_eq("s3_hold_tile", 32'(s_tile), 32'd3);
    wt_ready = 1'b1;
    cycle(); cycle();
    check_eq("s3_adv_tile", 32'(s_tile), 32'd4);
    check_eq("s3_adv_u", 32'(s_u), 32'd1);
    repeat (TOTAL) cycle();

    // abort coincident with the final handshake
    clear_obs();
    start = 1'b1; cycle(); start = 1'b0;
    run_to(TOTAL - 1);
    abort = 1'b1; cycle(); abort = 1'b0;
    repeat (5) cycle();
    check_eq("s4_no_done", 32'(done_obs), 32'd0);
    check_eq("s4_idle", 32'(s_busy), 32'd0);

    // start while busy is ignored
    clear_obs();
    start = 1'b1; cycle(); start = 1'b0;
    run_to(2 * TP);
    start = 1'b1; cycle(); start = 1'b0;
    repeat (TOTAL + 5) cycle();
    check_eq("s5_handshakes", 32'(hs_obs), 32'(TOTAL));
    check_eq("s5_done_count", 32'(done_obs), 32'd1);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 39) == 0);
      wt_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    start = 1'b0; abort = 1'b0; wt_ready = 1'b1;
    repeat (TOTAL + 5) cycle();

    // small configuration: 2 convs, 1 tile each
    hs2 = 0; done2c = 0; maxu2 = 0; hsu[0] = -1; hsu[1] = -1;
    start2 = 1'b1; ready2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy2 && int'(u2) > maxu2) maxu2 = int'(u2);
      if (valid2 && ready2) begin
        if (hs2 < 2) hsu[hs2] = int'(u2);
        hs2++;
      end
      if (done2) done2c++;
      @(posedge clk); #1;
      start2 = 1'b0;
    end
    check_eq("s6_handshakes", 32'(hs2), 32'd2);
    check_eq("s6_first_u", 32'(hsu[0]), 32'd0);
    check_eq("s6_second_u", 32'(hsu[1]), 32'd1);
    check_eq("s6_done_count", 32'(done2c), 32'd1);
    check_eq("s6_max_u", 32'(maxu2), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
